// File: rtl/digit_chain_counter_pkg.sv
// Shared constants and FSM encoding for the digit chain counter.
package digit_chain_counter_pkg;

  localparam int unsigned L_DEF      = 10;
  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned DIGIT_W    = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/digit_chain_counter_if.sv
// Control/status bundle between the counter and its driver.
interface digit_chain_counter_if #(
  parameter int unsigned DIGITS = digit_chain_counter_pkg::DIGITS_DEF
);

  localparam int unsigned CW = digit_chain_counter_pkg::DIGIT_W * DIGITS;

  logic          tick;
  logic          up;
  logic          start;
  logic          stop;
  logic          clear;
  logic          load;
  logic [CW-1:0] load_val;
  logic [CW-1:0] count;
  logic          running;
  logic          wrap_hi;
  logic          wrap_lo;

  modport master (
    output tick, up, start, stop, clear, load, load_val,
    input  count, running, wrap_hi, wrap_lo
  );

  modport slave (
    input  tick, up, start, stop, clear, load, load_val,
    output count, running, wrap_hi, wrap_lo
  );

endinterface

// File: rtl/digit_chain_counter_inc_dec.sv
// Single-digit base-L incrementor/decrementor with overflow/underflow flags.
module digit_chain_counter_inc_dec
  import digit_chain_counter_pkg::*;
#(
  parameter int unsigned L = L_DEF
) (
  input  logic [DIGIT_W-1:0] d,
  input  logic               ci,
  input  logic               cid,
  output logic [DIGIT_W-1:0] q_c,
  output logic               ovf_c,
  output logic               unf_c
);

  logic [5:0] z_c;

  // z = d + ci - cid in a signed 6-bit space, then fold into 0..L-1.
  always_comb begin
    z_c   = 6'(d) + 6'(ci) - 6'(cid);
    q_c   = z_c[DIGIT_W-1:0];
    ovf_c = 1'b0;
    unf_c = 1'b0;
    if (z_c[5]) begin
      q_c   = DIGIT_W'(L - 1);
      unf_c = 1'b1;
    end else if (z_c >= 6'(L)) begin
      q_c   = '0;
      ovf_c = 1'b1;
    end
  end

endmodule

// File: rtl/digit_chain_counter.sv
// Registered multi-digit base-L up/down counter with run/stop FSM.
// Optional build macro: DIGIT_CHAIN_SATURATE_EN (clamp at the ends and stop).
module digit_chain_counter
  import digit_chain_counter_pkg::*;
#(
  parameter int unsigned L      = L_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_chain_counter_if.slave bus
);

  localparam int unsigned CW = DIGIT_W * DIGITS;

  state_e          state_q;
  state_e          state_nxt;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   chain_c;
  logic [CW-1:0]   load_clamp_c;
  logic [DIGITS-1:0] ci_c;
  logic [DIGITS-1:0] cid_c;
  logic [DIGITS-1:0] ovf_c;
  logic [DIGITS-1:0] unf_c;
  logic            wrap_hi_q;
  logic            wrap_lo_q;
  logic            running_c;
  logic            tick_apply_c;

  // Ripple chain: each stage's flags are the next stage's carry/borrow.
  for (genvar g = 0; g < DIGITS; g++) begin : g_stage
    if (g == 0) begin : g_lsd
      assign ci_c[g]  = bus.tick & bus.up;
      assign cid_c[g] = bus.tick & ~bus.up;
    end else begin : g_upper
      assign ci_c[g]  = ovf_c[g-1];
      assign cid_c[g] = unf_c[g-1];
    end

    digit_chain_counter_inc_dec #(.L(L)) u_stage (
      .d     (count_q[g*DIGIT_W +: DIGIT_W]),
      .ci    (ci_c[g]),
      .cid   (cid_c[g]),
      .q_c   (chain_c[g*DIGIT_W +: DIGIT_W]),
      .ovf_c (ovf_c[g]),
      .unf_c (unf_c[g])
    );
  end

  // Clamp out-of-range load fields to the top digit value.
  always_comb begin
    load_clamp_c = bus.load_val;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (5'(bus.load_val[i*DIGIT_W +: DIGIT_W]) >= 5'(L)) begin
        load_clamp_c[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(L - 1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next state: stop beats start; saturation can force a stop.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (bus.start && !bus.stop) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.stop) state_nxt = S_IDLE;
`ifdef DIGIT_CHAIN_SATURATE_EN
        if (tick_apply_c && (ovf_c[DIGITS-1] || unf_c[DIGITS-1])) state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: run flag and whether this cycle's tick is applied.
  always_comb begin
    running_c    = 1'b0;
    tick_apply_c = 1'b0;
    if (state_q == S_RUN) begin
      running_c    = 1'b1;
      tick_apply_c = bus.tick & ~bus.clear & ~bus.load;
    end
  end

  // Next count: clear, then load, then applied tick, else hold.
  always_comb begin
    count_nxt = count_q;
    if (bus.clear) begin
      count_nxt = '0;
    end else if (bus.load) begin
      count_nxt = load_clamp_c;
    end else if (tick_apply_c) begin
`ifdef DIGIT_CHAIN_SATURATE_EN
      if (ovf_c[DIGITS-1]) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          count_nxt[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(L - 1);
        end
      end else if (unf_c[DIGITS-1]) begin
        count_nxt = '0;
      end else begin
        count_nxt = chain_c;
      end
`else
      count_nxt = chain_c;
`endif
    end
  end

  // Count and wrap pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wrap_hi_q <= 1'b0;
      wrap_lo_q <= 1'b0;
    end else begin
      count_q   <= count_nxt;
      wrap_hi_q <= tick_apply_c & ovf_c[DIGITS-1];
      wrap_lo_q <= tick_apply_c & unf_c[DIGITS-1];
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_c;
  assign bus.wrap_hi = wrap_hi_q;
  assign bus.wrap_lo = wrap_lo_q;

endmodule

// File: tb/tb_digit_chain_counter.sv
// Directed bench for digit_chain_counter (L=10, DIGITS=4).
module tb_digit_chain_counter;

`ifdef DIGIT_CHAIN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic        tick, up, start, stop, clear, load;
    logic [15:0] lv;
    logic [15:0] ec;
    logic        er, ewh, ewl;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vq[$];

  digit_chain_counter_if #(.DIGITS(4)) bus ();

  digit_chain_counter #(.L(10), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] ec, input logic er,
                         input logic ewh, input logic ewl);
    chk({nm, ".count"},   bus.count,          ec);
    chk({nm, ".running"}, 16'(bus.running),   16'(er));
    chk({nm, ".wrap_hi"}, 16'(bus.wrap_hi),   16'(ewh));
    chk({nm, ".wrap_lo"}, 16'(bus.wrap_lo),   16'(ewl));
  endtask

  task automatic add(input string nm, input logic tick, input logic up, input logic start,
                     input logic stop, input logic clear, input logic load,
                     input logic [15:0] lv, input logic [15:0] ec, input logic er,
                     input logic ewh, input logic ewl);
    vec_t v;
    v.nm = nm; v.tick = tick; v.up = up; v.start = start; v.stop = stop;
    v.clear = clear; v.load = load; v.lv = lv; v.ec = ec; v.er = er;
    v.ewh = ewh; v.ewl = ewl;
    vq.push_back(v);
  endtask

  task automatic drive(input logic tick, input logic up, input logic start, input logic stop,
                       input logic clear, input logic load, input logic [15:0] lv);
    bus.tick = tick; bus.up = up; bus.start = start; bus.stop = stop;
    bus.clear = clear; bus.load = load; bus.load_val = lv;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //   name          tk up st sp cl ld load_val  count                       run         whi wlo
    add("start",       0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000,                   1,          0, 0);
    add("up1",         1, 1, 0, 0, 0, 0, 16'h0000, 16'h0001,                   1,          0, 0);
    add("up2",         1, 1, 0, 0, 0, 0, 16'h0000, 16'h0002,                   1,          0, 0);
    add("up3",         1, 1, 0, 0, 0, 0, 16'h0000, 16'h0003,                   1,          0, 0);
    add("ld0999",      0, 0, 0, 0, 0, 1, 16'h0999, 16'h0999,                   1,          0, 0);
    add("ripple_up",   1, 1, 0, 0, 0, 0, 16'h0000, 16'h1000,                   1,          0, 0);
    add("ld9999",      0, 0, 0, 0, 0, 1, 16'h9999, 16'h9999,                   1,          0, 0);
    add("wrap_hi",     1, 1, 0, 0, 0, 0, 16'h0000, SAT ? 16'h9999 : 16'h0000,  !SAT,       1, 0);
    add("wrap_hi_end", 0, 0, 0, 0, 0, 0, 16'h0000, SAT ? 16'h9999 : 16'h0000,  !SAT,       0, 0);
    add("clr",         0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000,                   !SAT,       0, 0);
    add("restart",     0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000,                   1,          0, 0);
    add("wrap_lo",     1, 0, 0, 0, 0, 0, 16'h0000, SAT ? 16'h0000 : 16'h9999,  !SAT,       0, 1);
    add("wrap_lo_end", 0, 0, 0, 0, 0, 0, 16'h0000, SAT ? 16'h0000 : 16'h9999,  !SAT,       0, 0);
    add("stop",        0, 0, 0, 1, 0, 0, 16'h0000, SAT ? 16'h0000 : 16'h9999,  0,          0, 0);
    add("clr_idle",    0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000,                   0,          0, 0);
    for (int i = 0; i < 4; i++)
      add("idle_up",   1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000,                   0,          0, 0);
    add("idle_dn",     1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000,                   0,          0, 0);
    add("ld_clamp",    0, 0, 0, 0, 0, 1, 16'hFA3C, 16'h9939,                   0,          0, 0);
    add("start_stop",  0, 0, 1, 1, 0, 0, 16'h0000, 16'h9939,                   0,          0, 0);
    add("start_tick",  1, 1, 1, 0, 0, 0, 16'h0000, 16'h9939,                   1,          0, 0);
    add("run_up",      1, 1, 0, 0, 0, 0, 16'h0000, 16'h9940,                   1,          0, 0);
    add("stop_tick",   1, 1, 0, 1, 0, 0, 16'h0000, 16'h9941,                   0,          0, 0);
    add("start2",      0, 0, 1, 0, 0, 0, 16'h0000, 16'h9941,                   1,          0, 0);
    add("dn_a",        1, 0, 0, 0, 0, 0, 16'h0000, 16'h9940,                   1,          0, 0);
    add("dn_borrow",   1, 0, 0, 0, 0, 0, 16'h0000, 16'h9939,                   1,          0, 0);
    add("clr_ld_tick", 1, 1, 0, 0, 1, 1, 16'h1234, 16'h0000,                   1,          0, 0);
    add("ld_over_tk",  1, 0, 0, 0, 0, 1, 16'h0001, 16'h0001,                   1,          0, 0);
    add("dn_to_zero",  1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000,                   1,          0, 0);
    add("ld_no_wrap",  1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000,                   1,          0, 0);
    add("ld1000",      0, 0, 0, 0, 0, 1, 16'h1000, 16'h1000,                   1,          0, 0);
    add("ripple_dn",   1, 0, 0, 0, 0, 0, 16'h0000, 16'h0999,                   1,          0, 0);

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 16'h0000);
    #12;
    chk_all("reset", 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table sweep: drive on the falling edge, sample just after the rising edge.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].tick, vq[i].up, vq[i].start, vq[i].stop, vq[i].clear, vq[i].load, vq[i].lv);
      @(posedge clk);
      #1;
      chk_all(vq[i].nm, vq[i].ec, vq[i].er, vq[i].ewh, vq[i].ewl);
    end

    // Asynchronous reset between edges while running with tick held.
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 16'h0000, 0, 0, 0);

    // Recovery after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 16'h0000);
    @(posedge clk);
    #1;
    chk_all("post_rst_start", 16'h0000, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 16'h0000);
    @(posedge clk);
    #1;
    chk_all("post_rst_up", 16'h0001, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
